accum_calc: RTL and testbench

- 16-bit accumulator calculator for a board with five push-buttons, a 16-bit switch bank and 16 LEDs.
- Each operation combines the accumulator with the switch value. The operation is selected by three buttons (left, center, right), and the result is committed to the accumulator by the down button.
- LEDs always show the accumulator.
- Arithmetic is done in a 32-bit combinational ALU sub-module. The register file is a separate block and not part of this spec.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/alu_core.sv | 49 ++++
 rtl/accum_calc.sv | 96 +++++++++
 tb/tb_accum_calc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//
// Shared definitions for the accumulator calculator:
//   - ACC_W / ALU_W : accumulator and ALU datapath widths
//   - ALUOP_*       : 4-bit op codes understood by alu_core
//   - calc_op_e     : 3-bit button op select, indexed as {left, center, right}
//   - sext_acc()    : sign-extends an accumulator-width value to ALU width
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int ACC_W = 16;
    localparam int ALU_W = 32;

    // alu_core op codes. Codes not listed here make the ALU return zero.
    localparam logic [3:0] ALUOP_AND  = 4'b0000;
    localparam logic [3:0] ALUOP_OR   = 4'b0001;
    localparam logic [3:0] ALUOP_ADD  = 4'b0010;
    localparam logic [3:0] ALUOP_NOR  = 4'b0100;
    localparam logic [3:0] ALUOP_XOR  = 4'b0101;
    localparam logic [3:0] ALUOP_SUB  = 4'b0110;
    localparam logic [3:0] ALUOP_LESS = 4'b0111;
    localparam logic [3:0] ALUOP_SRL  = 4'b1000;
    localparam logic [3:0] ALUOP_SLL  = 4'b1001;
    localparam logic [3:0] ALUOP_SRA  = 4'b1010;

    // Calculator operation as selected by the {left, center, right} buttons.
    typedef enum logic [2:0] {
        CALC_ADD  = 3'b000,
        CALC_SUB  = 3'b001,
        CALC_OR   = 3'b010,
        CALC_AND  = 3'b011,
        CALC_XOR  = 3'b100,
        CALC_LESS = 3'b101,
        CALC_SLL  = 3'b110,
        CALC_SRA  = 3'b111
    } calc_op_e;

    // Sign-extend an accumulator-width operand to the ALU datapath width.
    function automatic logic [ALU_W-1:0] sext_acc(input logic [ACC_W-1:0] v);
        return {{(ALU_W-ACC_W){v[ACC_W-1]}}, v};
    endfunction

endpackage : calc_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//
// Purely combinational 32-bit ALU.
//
// Ports:
//   op1    [31:0] in   first operand
//   op2    [31:0] in   second operand; op2[4:0] is the shift amount for shifts
//   alu_op [3:0]  in   operation code (calc_pkg::ALUOP_*)
//   zero          out  1 when result is all zeros
//   result [31:0] out  operation result
//
// ADD/SUB wrap in two's complement with no overflow indication. LESS is a
// signed compare returning 1 or 0. Unrecognised op codes produce 0.
// -----------------------------------------------------------------------------
module alu_core
    import calc_pkg::*;
(
    input  logic [ALU_W-1:0] op1,
    input  logic [ALU_W-1:0] op2,
    input  logic [3:0]       alu_op,
    output logic             zero,
    output logic [ALU_W-1:0] result
);

    // Only the low five bits select a shift distance; the rest are ignored.
    logic [4:0] shamt;
    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALUOP_AND:  result = op1 & op2;
            ALUOP_OR:   result = op1 | op2;
            ALUOP_ADD:  result = op1 + op2;
            ALUOP_SUB:  result = op1 - op2;
            ALUOP_LESS: result = ($signed(op1) < $signed(op2)) ? {{(ALU_W-1){1'b0}}, 1'b1} : '0;
            ALUOP_SRL:  result = op1 >> shamt;
            ALUOP_SLL:  result = op1 << shamt;
            ALUOP_SRA:  result = $unsigned($signed(op1) >>> shamt);
            ALUOP_XOR:  result = op1 ^ op2;
            ALUOP_NOR:  result = ~(op1 | op2);
            default:    result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule : alu_core

// File: rtl/accum_calc.sv
// -----------------------------------------------------------------------------
// accum_calc
//
// 16-bit accumulator calculator driven by five push-buttons and a switch bank.
// The accumulator is combined with the switches by an operation chosen with
// {left, center, right}; the result is committed when down is high at a
// rising clock edge. up clears the accumulator and wins over down.
//
// Ports:
//   clk             in   system clock, rising-edge active
//   up              in   synchronous active-high accumulator reset
//   center          in   op-select bit 1
//   left            in   op-select bit 2 (MSB)
//   right           in   op-select bit 0 (LSB)
//   down            in   accumulate strobe, level-sampled on every edge
//   switches [15:0] in   second operand
//   led      [15:0] out  current accumulator value (register output)
//
// Strobe semantics: down is not a valid/ready handshake and has no edge
// detection. Every rising edge with up=0 and down=1 performs one commit, so a
// held button keeps re-applying the operation once per clock.
// -----------------------------------------------------------------------------
module accum_calc
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             up,
    input  logic             center,
    input  logic             left,
    input  logic             right,
    input  logic             down,
    input  logic [ACC_W-1:0] switches,
    output logic [ACC_W-1:0] led
);

    logic [ACC_W-1:0] acc;

    calc_op_e         calc_op;
    logic [3:0]       alu_op;
    logic [ALU_W-1:0] op1;
    logic [ALU_W-1:0] op2;
    logic [ALU_W-1:0] alu_result;
    logic             alu_zero;

    // -------------------------------------------------------------------------
    // Button decode: {left, center, right} -> ALU op code
    // -------------------------------------------------------------------------
    assign calc_op = calc_op_e'({left, center, right});

    always_comb begin
        alu_op = ALUOP_ADD;
        case (calc_op)
            CALC_ADD:  alu_op = ALUOP_ADD;
            CALC_SUB:  alu_op = ALUOP_SUB;
            CALC_OR:   alu_op = ALUOP_OR;
            CALC_AND:  alu_op = ALUOP_AND;
            CALC_XOR:  alu_op = ALUOP_XOR;
            CALC_LESS: alu_op = ALUOP_LESS;
            CALC_SLL:  alu_op = ALUOP_SLL;
            CALC_SRA:  alu_op = ALUOP_SRA;
            default:   alu_op = ALUOP_ADD;
        endcase
    end

    // Both operands are sign-extended so LESS and SRA see 16-bit signed values.
    assign op1 = sext_acc(acc);
    assign op2 = sext_acc(switches);

    alu_core u_alu (
        .op1    (op1),
        .op2    (op2),
        .alu_op (alu_op),
        .zero   (alu_zero),
        .result (alu_result)
    );

    // The zero flag and the upper result half have no consumer here: results
    // are truncated to the accumulator width and overflow wraps silently.
    logic unused_alu_bits;
    assign unused_alu_bits = &{1'b0, alu_zero, alu_result[ALU_W-1:ACC_W]};

    // -------------------------------------------------------------------------
    // Accumulator register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (up) begin
            acc <= '0;
        end else if (down) begin
            acc <= alu_result[ACC_W-1:0];
        end
    end

    // LEDs come straight from the register; no combinational input path.
    assign led = acc;

endmodule : accum_calc

// File: tb/tb_accum_calc.sv
// -----------------------------------------------------------------------------
// tb_accum_calc
//
// Directed self-checking bench for accum_calc, plus a standalone alu_core
// instance for op-code level checks. Each scenario task drives its stimulus
// and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_accum_calc;

    // Clock / reset block
    logic        clk = 1'b0;
    logic        up = 1'b0;
    logic        center = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        down = 1'b0;
    logic [15:0] switches = 16'h0000;
    logic [15:0] led;

    always #5 clk = ~clk;

    accum_calc dut (
        .clk      (clk),
        .up       (up),
        .center   (center),
        .left     (left),
        .right    (right),
        .down     (down),
        .switches (switches),
        .led      (led)
    );

    // Standalone ALU
    logic [31:0] a_op1 = 32'd0;
    logic [31:0] a_op2 = 32'd0;
    logic [3:0]  a_op  = 4'd0;
    logic        a_zero;
    logic [31:0] a_res;

    alu_core u_alu_tb (
        .op1    (a_op1),
        .op2    (a_op2),
        .alu_op (a_op),
        .zero   (a_zero),
        .result (a_res)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    // Driver: set buttons/switches at the falling edge, let one rising edge
    // happen, then return 1 time unit later so led can be sampled.
    task automatic step(input logic rst, input logic dn, input logic [2:0] lcr,
                        input logic [15:0] sw);
        @(negedge clk);
        up       = rst;
        down     = dn;
        left     = lcr[2];
        center   = lcr[1];
        right    = lcr[0];
        switches = sw;
        @(posedge clk);
        #1;
    endtask

    // Reset then load a value with ADD from zero.
    task automatic load(input logic [15:0] v);
        step(1'b1, 1'b0, 3'b000, 16'h0000);
        step(1'b0, 1'b1, 3'b000, v);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 3'b000, 16'hffff);
        total++;
        if (led !== 16'h0000) begin
            bad++;
            $display("FAIL reset: led=%h expected 0000", led);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'b000, 16'h1234);
            total++;
            if (led !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold%0d: led=%h expected 0000", i, led);
            end
        end
    endtask

    task automatic test_add_sub_and;
        step(1'b0, 1'b1, 3'b000, 16'h354a);
        total++;
        if (led !== 16'h354a) begin
            bad++;
            $display("FAIL add: led=%h expected 354a", led);
        end
        step(1'b0, 1'b1, 3'b001, 16'h1234);
        total++;
        if (led !== 16'h2316) begin
            bad++;
            $display("FAIL sub: led=%h expected 2316", led);
        end
        step(1'b0, 1'b1, 3'b011, 16'hf0f0);
        total++;
        if (led !== 16'h2010) begin
            bad++;
            $display("FAIL and: led=%h expected 2010", led);
        end
        // down low: hold, even with a different op and operand presented
        step(1'b0, 1'b0, 3'b010, 16'hffff);
        total++;
        if (led !== 16'h2010) begin
            bad++;
            $display("FAIL hold: led=%h expected 2010", led);
        end
    endtask

    task automatic test_less;
        step(1'b0, 1'b1, 3'b101, 16'h8000);
        total++;
        if (led !== 16'h0000) begin
            bad++;
            $display("FAIL less_neg: led=%h expected 0000", led);
        end
        load(16'h2010);
        step(1'b0, 1'b1, 3'b101, 16'h7fff);
        total++;
        if (led !== 16'h0001) begin
            bad++;
            $display("FAIL less_pos: led=%h expected 0001", led);
        end
    endtask

    task automatic test_sra;
        load(16'h8000);
        total++;
        if (led !== 16'h8000) begin
            bad++;
            $display("FAIL sra_load: led=%h expected 8000", led);
        end
        step(1'b0, 1'b1, 3'b111, 16'h0004);
        total++;
        if (led !== 16'hf800) begin
            bad++;
            $display("FAIL sra_neg: led=%h expected f800", led);
        end
        load(16'h4000);
        step(1'b0, 1'b1, 3'b111, 16'h0004);
        total++;
        if (led !== 16'h0400) begin
            bad++;
            $display("FAIL sra_pos: led=%h expected 0400", led);
        end
        // sw=0x8010: only op2[4:0]=16 counts; 0xffff8000 >>> 16 = all ones
        load(16'h8000);
        step(1'b0, 1'b1, 3'b111, 16'h8010);
        total++;
        if (led !== 16'hffff) begin
            bad++;
            $display("FAIL sra_16: led=%h expected ffff", led);
        end
    endtask

    task automatic test_wrap_xor_or;
        // 0 - 1 wraps to 0xffff
        step(1'b1, 1'b0, 3'b000, 16'h0000);
        step(1'b0, 1'b1, 3'b001, 16'h0001);
        total++;
        if (led !== 16'hffff) begin
            bad++;
            $display("FAIL sub_wrap: led=%h expected ffff", led);
        end
        // 0xffff + 1 wraps to 0
        step(1'b0, 1'b1, 3'b000, 16'h0001);
        total++;
        if (led !== 16'h0000) begin
            bad++;
            $display("FAIL add_wrap: led=%h expected 0000", led);
        end
        step(1'b0, 1'b1, 3'b010, 16'h0a50);
        total++;
        if (led !== 16'h0a50) begin
            bad++;
            $display("FAIL or: led=%h expected 0a50", led);
        end
        step(1'b0, 1'b1, 3'b100, 16'hffff);
        total++;
        if (led !== 16'hf5af) begin
            bad++;
            $display("FAIL xor: led=%h expected f5af", led);
        end
    endtask

    task automatic test_back_to_back;
        load(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0008);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] e;
            step(1'b0, 1'b1, 3'b110, 16'h0001);
            e = exp_q.pop_front();
            total++;
            if (led !== e) begin
                bad++;
                $display("FAIL sll_held%0d: led=%h expected %h", i, led, e);
            end
        end
        // shift amount comes from the low five bits only (0x21 -> 1)
        step(1'b0, 1'b1, 3'b110, 16'h0021);
        total++;
        if (led !== 16'h0010) begin
            bad++;
            $display("FAIL sll_shamt: led=%h expected 0010", led);
        end
        step(1'b1, 1'b1, 3'b110, 16'h0001);
        total++;
        if (led !== 16'h0000) begin
            bad++;
            $display("FAIL up_priority: led=%h expected 0000", led);
        end
    endtask

    task automatic test_alu;
        logic [3:0]  ops  [11];
        logic [31:0] exps [11];
        ops[0]  = 4'b0000; exps[0]  = 32'd0;          // AND
        ops[1]  = 4'b0001; exps[1]  = 32'd3;          // OR
        ops[2]  = 4'b0010; exps[2]  = 32'd3;          // ADD
        ops[3]  = 4'b0110; exps[3]  = 32'd1;          // SUB
        ops[4]  = 4'b0111; exps[4]  = 32'd0;          // LESS
        ops[5]  = 4'b1001; exps[5]  = 32'd4;          // SLL
        ops[6]  = 4'b1000; exps[6]  = 32'd1;          // SRL
        ops[7]  = 4'b0101; exps[7]  = 32'd3;          // XOR
        ops[8]  = 4'b1111; exps[8]  = 32'd0;          // unused code
        ops[9]  = 4'b0100; exps[9]  = 32'hfffffffc;   // NOR
        ops[10] = 4'b1010; exps[10] = 32'd1;          // SRA
        a_op1 = 32'd2;
        a_op2 = 32'd1;
        for (int i = 0; i < 11; i++) begin
            a_op = ops[i];
            #1;
            total++;
            if (a_res !== exps[i] || a_zero !== (exps[i] == 32'd0)) begin
                bad++;
                $display("FAIL alu_op%b: result=%h zero=%b expected %h zero=%b",
                         ops[i], a_res, a_zero, exps[i], (exps[i] == 32'd0));
            end
        end
        // Signed compare and arithmetic shift on negative operands
        a_op1 = 32'hfffffff0;
        a_op2 = 32'h00000001;
        a_op  = 4'b0111;
        #1;
        total++;
        if (a_res !== 32'd1 || a_zero !== 1'b0) begin
            bad++;
            $display("FAIL alu_less_neg: result=%h zero=%b expected 00000001 zero=0", a_res, a_zero);
        end
        a_op2 = 32'hffffffe4;  // shift amount 4
        a_op  = 4'b1010;
        #1;
        total++;
        if (a_res !== 32'hffffffff) begin
            bad++;
            $display("FAIL alu_sra_neg: result=%h expected ffffffff", a_res);
        end
        a_op  = 4'b1000;
        #1;
        total++;
        if (a_res !== 32'h0fffffff) begin
            bad++;
            $display("FAIL alu_srl_neg: result=%h expected 0fffffff", a_res);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub_and();
        test_less();
        test_sra();
        test_wrap_xor_or();
        test_back_to_back();
        test_alu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_accum_calc
